// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer: entry layout, index/tag sizing,
// and saturating counter arithmetic.
package bp_pkg;

  localparam int unsigned BP_ADDR_W  = 32;
  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_CTR_W   = 2;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned entries);
    return addr_w - $clog2(entries);
  endfunction

  // Weakly-taken encoding: only the MSB of a w-bit counter set.
  function automatic logic [63:0] ctr_weak_taken(input int unsigned w);
    return 64'(1) << (w - 1);
  endfunction

  function automatic logic [63:0] ctr_sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v >= max) ? v : v + 64'd1;
  endfunction

  function automatic logic [63:0] ctr_sat_dec(input logic [63:0] v);
    return (v == 64'd0) ? v : v - 64'd1;
  endfunction

  localparam int unsigned BP_IDX_W = idx_w(BP_ENTRIES);
  localparam int unsigned BP_TAG_W = tag_w(BP_ADDR_W, BP_ENTRIES);

  localparam logic [BP_CTR_W-1:0] CTR_WEAK_TAKEN = BP_CTR_W'(ctr_weak_taken(BP_CTR_W));

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_CTR_W-1:0]  ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup and EX-side resolution signals between the pipeline and the BTB.
interface branch_predictor_btb_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              ex_valid;
  logic              ex_is_branch;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              btb_flush;

  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target, btb_flush,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target, btb_flush,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/sat_counter.sv
// Up/down saturating counter with synchronous reset, enable and parallel load (load wins).
module sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = up ? W'(ctr_sat_inc(64'(cnt_q), 64'(CNT_MAX)))
                 : W'(ctr_sat_dec(64'(cnt_q)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters: zero-latency lookup in IF,
// training and mispredict detection from EX resolution, saturating branch statistics.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = BP_ADDR_W,
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned CTR_W   = BP_CTR_W,
  parameter int unsigned STAT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predictor_btb_if.slave bus,
  output logic [STAT_W-1:0]    stat_branches,
  output logic [STAT_W-1:0]    stat_mispredicts
);
  localparam int unsigned      IDX_W    = idx_w(ENTRIES);
  localparam int unsigned      TAG_W    = tag_w(ADDR_W, ENTRIES);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_weak_taken(CTR_W));

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr      [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit, upd, tbl_upd, misp;

  // Both ports decode against registered state, so a same-index update is seen next cycle.
  always_comb begin
    rd_idx  = bus.if_pc[IDX_W-1:0];
    rd_tag  = bus.if_pc[ADDR_W-1:IDX_W];
    wr_idx  = bus.ex_pc[IDX_W-1:0];
    wr_tag  = bus.ex_pc[ADDR_W-1:IDX_W];
    rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    upd     = bus.ex_valid && bus.ex_is_branch;
    tbl_upd = upd && !bus.btb_flush;
    misp    = upd && ((bus.ex_taken != bus.ex_pred_taken) ||
                      (bus.ex_taken && bus.ex_pred_taken && (bus.ex_target != bus.ex_pred_target)));
  end

  assign bus.pred_hit    = rd_hit;
  assign bus.pred_taken  = rd_hit && ctr[rd_idx][CTR_W-1];
  assign bus.pred_target = bus.pred_taken ? target_q[rd_idx] : bus.if_pc + ADDR_W'(1);
  assign bus.mispredict  = misp;
  assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_W'(1);

  // A taken resolution either refreshes a hit or allocates over any alias; same write either way.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bus.btb_flush) begin
      valid_d = '0;
    end else if (upd && bus.ex_taken) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = bus.ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_ctr
    logic sel;
    assign sel = (wr_idx == IDX_W'(i));
    sat_counter #(.W(CTR_W)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .en       (tbl_upd && wr_hit && sel),
      .up       (bus.ex_taken),
      .load     (tbl_upd && !wr_hit && bus.ex_taken && sel),
      .load_val (CTR_INIT),
      .cnt      (ctr[i])
    );
  end

  // Statistics keep counting through a flush; only reset clears them.
  sat_counter #(.W(STAT_W)) u_stat_br (
    .clk      (clk),
    .reset    (reset),
    .en       (upd),
    .up       (1'b1),
    .load     (1'b0),
    .load_val ('0),
    .cnt      (stat_branches)
  );

  sat_counter #(.W(STAT_W)) u_stat_mp (
    .clk      (clk),
    .reset    (reset),
    .en       (misp),
    .up       (1'b1),
    .load     (1'b0),
    .load_val ('0),
    .cnt      (stat_mispredicts)
  );
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the pipelined MIPS core.
- Predicts next PC in IF from the current PC, replacing the fixed PC+1 fetch.
- Trains from branch/jump resolution in EX.
- Generates mispredict/redirect and keeps saturating statistics counters. Successor to the core's static "predict not-taken, flush on beq" scheme.

Parameters:
- ADDR_W, 32, PC width; the PC is a word address, so sequential PC = PC+1.
- ENTRIES, 16, BTB entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width, ≥1.
- STAT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_pc  in  ADDR_W  PC being fetched
- pred_hit  out  1  valid entry with tag match for if_pc
- pred_taken  out  1  predicted taken
- pred_target  out  ADDR_W  predicted next PC
- ex_valid  in  1  EX holds a real (unflushed) instruction
- ex_is_branch  in  1  EX instruction is a beq/j/jr
- ex_pc  in  ADDR_W  PC of the EX instruction
- ex_taken  in  1  resolved direction
- ex_target  in  ADDR_W  resolved target (meaningful when ex_taken=1)
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- ex_pred_target  in  ADDR_W  predicted target carried down the pipe
- btb_flush  in  1  invalidate all entries
- mispredict  out  1  redirect the front end and flush IF/ID and ID/EX
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1
- stat_branches  out  STAT_W  resolved branch count
- stat_mispredicts  out  STAT_W  mispredict count

Behaviour:

Indexing:
- idx = pc[IDX_W-1:0]
- tag = pc[ADDR_W-1:IDX_W]
- Direct-mapped. Per entry: valid, tag, target[ADDR_W], ctr[CTR_W].

Lookup (combinational from registered state, zero latency):
- pred_hit = valid[idx] & (tag match).
- pred_taken = pred_hit & ctr[CTR_W-1].
- pred_target = pred_taken ? target[idx] : if_pc+1. Modulo 2^ADDR_W, so it wraps at all-ones.

Resolution (combinational):
- upd = ex_valid & ex_is_branch.
- mispredict = upd & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- redirect_pc = ex_taken ? ex_target : ex_pc+1. It is driven regardless of mispredict.

Update (at rising clk, when upd=1, applied to entry e = idx(ex_pc)):
- Hit (valid & tag match):
  - ctr saturating increment if taken, decrement if not taken. Bounds are 0 and 2^CTR_W-1.
  - If taken, target←ex_target.
- Miss and taken: allocate e, overwriting any alias.
  - valid←1, tag←tag(ex_pc), target←ex_target.
  - ctr←2^(CTR_W-1), i.e. weakly taken.
- Miss and not taken: no change.

Statistics:
- stat_branches increments on upd.
- stat_mispredicts increments on mispredict.
- Both saturate at all-ones; they never wrap.

Precedence per edge: reset > btb_flush > update.
- reset: all valid←0, ctr←0, target←0, tag←0, stats←0.
- btb_flush: valid←0 only. Stats still count this cycle's upd/mispredict. The table update is dropped.

Same-cycle lookup and update to the same index:
- Lookup returns the pre-update contents (read-before-write).
- The new contents are visible from the next cycle.

Reset values of outputs (follow from table state):
- pred_hit=0, pred_taken=0, pred_target=if_pc+1, stats=0.
- mispredict and redirect_pc remain purely input-driven.

Other rules:
- Reset asserted mid-training discards all state at that edge.
- No stall input: the pipeline must deassert ex_valid for bubbles and stalled duplicates, so each instruction updates exactly once.

Decomposition:
- Shared package `bp_pkg`:
  - btb_entry_t struct: valid, tag, target, ctr.
  - Functions: ctr_sat_inc, ctr_sat_dec.
  - Constant CTR_WEAK_TAKEN.
  - Localparam helpers for IDX_W and TAG_W.
- One natural sub-module: `sat_counter`, a parametrised up/down saturating counter with sync reset and enable. It serves both the direction counters (generated per entry) and the two stats counters.

Test Plan (ENTRIES=16, CTR_W=2, ADDR_W=32 unless noted):
1. Reset, then if_pc=0x10 → pred_hit=0, pred_taken=0, pred_target=0x11, stats=0. Also if_pc=0xFFFFFFFF → pred_target=0x0.
2. Update ex_pc=0x10, taken, ex_target=0x4, ex_pred_taken=0.
   - Same cycle: mispredict=1, redirect_pc=0x4.
   - Next cycle, if_pc=0x10: pred_hit=1, pred_taken=1, pred_target=0x4, ctr=2. stat_branches=1, stat_mispredicts=1.
3. Three not-taken updates at 0x10 → ctr 2→1→0→0.
   - pred_taken=0 after the first; pred_target=0x11; pred_hit stays 1.
   - Two taken updates then → ctr 2, pred_taken=1.
4. Alias: taken update at ex_pc=0x20 (idx 0, different tag), target 0x8.
   - Lookup 0x10 → pred_hit=0.
   - Lookup 0x20 → target 0x8.
   - Not-taken update at miss pc 0x30 → no allocation.
5. Target mismatch: ex_pred_taken=1, ex_pred_target=0x4, ex_taken=1, ex_target=0x6 → mispredict=1, redirect_pc=0x6.
   - Predicted taken, actually not taken at ex_pc=0x10 → redirect_pc=0x11.
   - ex_valid=0 with the same inputs → mispredict=0, no stat change.
6. Precedence:
   - btb_flush together with a taken update → all pred_hit=0 next cycle; stat_branches still increments.
   - reset together with update → all state zero.
   - STAT_W=4: 20 updates → stat_branches=15.
   - Same-index lookup during update → old prediction that cycle, new prediction the next.
